// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the writeback arbiter slice.
//   XLEN        : register data width
//   REG_ADDR_W  : register file address width
//   ZERO_REG    : architectural x0 (hard-wired zero register)
//   wb_entry_t  : one writeback result {rd, data}, also the FIFO element type
// -----------------------------------------------------------------------------
`default_nettype none

package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage : wb_pkg

`default_nettype wire

// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_if
// Bundles the writeback arbiter's result sources and register-file write port.
//   pipe_valid/pipe_rd/pipe_data : in-order pipeline result (no backpressure)
//   ll_valid/ll_ready/ll_rd/ll_data : long-latency result, valid/ready
//   pipe_stall : advisory hold request back to the pipeline
//   rd_addr/wr_data/wr_en : registered register-file write port
//   fifo_count : number of buffered long-latency results
// Modports:
//   master : result producers / register-file side (drives the inputs)
//   slave  : the arbiter
// -----------------------------------------------------------------------------
`default_nettype none

interface wb_arbiter_if #(
  parameter int DEPTH = 2
);
  import wb_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  pipe_valid;
  logic [REG_ADDR_W-1:0] pipe_rd;
  logic [XLEN-1:0]       pipe_data;

  logic                  ll_valid;
  logic                  ll_ready;
  logic [REG_ADDR_W-1:0] ll_rd;
  logic [XLEN-1:0]       ll_data;

  logic                  pipe_stall;

  logic [REG_ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  wr_en;

  logic [CNT_W-1:0]      fifo_count;

  modport master (
    output pipe_valid, pipe_rd, pipe_data,
    output ll_valid, ll_rd, ll_data,
    input  ll_ready, pipe_stall,
    input  rd_addr, wr_data, wr_en, fifo_count
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data,
    input  ll_valid, ll_rd, ll_data,
    output ll_ready, pipe_stall,
    output rd_addr, wr_data, wr_en, fifo_count
  );

endinterface : wb_arbiter_if

`default_nettype wire

// File: rtl/wb_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous DEPTH-entry FIFO of wb_entry_t used to park long-latency results
// while the pipeline owns the register-file write port.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears pointers/count)
//   i_push    : write i_entry at the tail (caller guarantees not full)
//   i_entry   : entry to push
//   i_pop     : drop the head (caller guarantees not empty)
//   o_head    : current head entry (valid when !o_empty)
//   o_count   : occupancy, 0..DEPTH
//   o_empty   : occupancy is zero
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
`default_nettype none

module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_push,
  input  wire wb_entry_t        i_entry,
  input  wire logic             i_pop,
  output wb_entry_t             o_head,
  output logic      [CNT_W-1:0] o_count,
  output logic                  o_empty
);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage is data only; contents behind an empty FIFO are never observed.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule : wb_fifo

`default_nettype wire

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Writeback arbiter for the single write port of register_file. Merges
// in-order pipeline results (fixed highest priority, no backpressure) with
// long-latency results (valid/ready), parking the latter in wb_fifo while the
// pipeline owns the port. Raises an advisory pipe_stall when buffered results
// have gone STARVE_LIMIT consecutive cycles without being drained.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset; flushes the FIFO and any
//          accepted-but-unwritten results
//   bus  : wb_arbiter_if.slave (sources, stall, write port, fifo_count)
// Parameters:
//   DEPTH        : long-latency FIFO entries (power of two, >= 2)
//   STARVE_LIMIT : non-pop cycles with a non-empty FIFO before pipe_stall
// Optional build macro:
//   WB_X0_FILTER_EN : drop results targeting x0 instead of writing them; a
//                     pipeline x0 result then frees the port for a FIFO pop.
// -----------------------------------------------------------------------------
`default_nettype none

module wb_arbiter
  import wb_pkg::*;
#(
  parameter  int DEPTH        = 2,
  parameter  int STARVE_LIMIT = 4,
  localparam int CNT_W        = $clog2(DEPTH) + 1,
  localparam int SW           = $clog2(STARVE_LIMIT + 1)
) (
  input  wire logic    clk,
  input  wire logic    rst,
  wb_arbiter_if.slave  bus
);

  // FIFO interface
  logic             w_push;
  logic             w_pop;
  wb_entry_t        w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_empty;

  // Source qualification
  logic             w_ll_ready;
  logic             w_ll_fire;
  logic             w_pipe_take;
  logic             w_ll_keep;
  wb_entry_t        w_ll_entry;
  wb_entry_t        w_pipe_entry;

  // Selection for the output register
  logic             w_sel_vld;
  wb_entry_t        w_sel;

  // Output register stage
  logic                  r_vld_p1;
  logic [REG_ADDR_W-1:0] r_rd_p1;
  logic [XLEN-1:0]       r_data_p1;

  logic [SW-1:0]         r_starve;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_ll_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign w_ll_entry   = '{rd: bus.ll_rd,   data: bus.ll_data};
  assign w_pipe_entry = '{rd: bus.pipe_rd, data: bus.pipe_data};

  // ll_ready depends only on registered occupancy so the long-latency source
  // never sees a combinational path from its own valid.
  assign w_ll_ready = !rst && (w_count < CNT_W'(DEPTH));
  assign w_ll_fire  = bus.ll_valid && w_ll_ready;

`ifdef WB_X0_FILTER_EN
  // An x0 pipeline result does not claim the port; an x0 ll result is
  // accepted by the handshake and then silently dropped.
  assign w_pipe_take = bus.pipe_valid && (bus.pipe_rd != ZERO_REG);
  assign w_ll_keep   = w_ll_fire && (bus.ll_rd != ZERO_REG);
`else
  assign w_pipe_take = bus.pipe_valid;
  assign w_ll_keep   = w_ll_fire;
`endif

  // Fixed priority: pipeline, then FIFO head, then direct ll bypass.
  // Bypass only happens with an empty FIFO, which keeps ll results in order.
  always_comb begin
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_sel_vld = 1'b0;
    w_sel     = w_pipe_entry;
    if (w_pipe_take) begin
      w_sel_vld = 1'b1;
      w_sel     = w_pipe_entry;
      w_push    = w_ll_keep;
    end else if (!w_empty) begin
      w_sel_vld = 1'b1;
      w_sel     = w_head;
      w_pop     = 1'b1;
      w_push    = w_ll_keep;
    end else if (w_ll_keep) begin
      w_sel_vld = 1'b1;
      w_sel     = w_ll_entry;
    end
  end

  // ---- stage p0 -> p1 : register-file write port ----
  // Address/data hold their last value when nothing is selected.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_rd_p1   <= '0;
      r_data_p1 <= '0;
    end else begin
      r_vld_p1 <= w_sel_vld;
      if (w_sel_vld) begin
        r_rd_p1   <= w_sel.rd;
        r_data_p1 <= w_sel.data;
      end
    end
  end

  // Counts consecutive cycles where buffered results could not drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_empty || w_pop) begin
      r_starve <= '0;
    end else if (r_starve < SW'(STARVE_LIMIT)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  assign bus.ll_ready   = w_ll_ready;
  assign bus.pipe_stall = (r_starve == SW'(STARVE_LIMIT));
  assign bus.rd_addr    = r_rd_p1;
  assign bus.wr_data    = r_data_p1;
  assign bus.wr_en      = r_vld_p1;
  assign bus.fifo_count = w_count;

endmodule : wb_arbiter

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none

module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
`ifdef WB_X0_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

  wb_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of pending ll results plus the expected write port.
  logic [36:0] m_q[$];
  bit          m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          m_starve;
  bit          m_fired;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit pv, input logic [4:0] prd, input logic [31:0] pdat,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ldat);
    bus.pipe_valid = pv;
    bus.pipe_rd    = prd;
    bus.pipe_data  = pdat;
    bus.ll_valid   = lv;
    bus.ll_rd      = lrd;
    bus.ll_data    = ldat;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // One clock: check pre-edge state, advance the model, check the write port.
  task automatic cyc();
    bit          ready, pv, keep, nonempty, popped;
    logic [36:0] head;
    #1;
    ready = !rst && (m_q.size() < DEPTH);
    check("ll_ready",   64'(bus.ll_ready),   64'(ready));
    check("fifo_count", 64'(bus.fifo_count), 64'(m_q.size()));
    check("pipe_stall", 64'(bus.pipe_stall), 64'(m_starve == LIMIT));
    m_fired  = bus.ll_valid && ready;
    pv       = bus.pipe_valid && !(FILT && bus.pipe_rd == 5'd0);
    keep     = m_fired && !(FILT && bus.ll_rd == 5'd0);
    nonempty = (m_q.size() != 0);
    popped   = 1'b0;
    if (rst) begin
      m_q.delete();
      m_wen = 1'b0; m_rd = '0; m_data = '0; m_starve = 0;
    end else begin
      if (pv) begin
        m_wen = 1'b1; m_rd = bus.pipe_rd; m_data = bus.pipe_data;
      end else if (nonempty) begin
        head = m_q.pop_front();
        popped = 1'b1;
        m_wen = 1'b1; {m_rd, m_data} = head;
      end else if (keep) begin
        m_wen = 1'b1; m_rd = bus.ll_rd; m_data = bus.ll_data;
        keep = 1'b0;
      end else begin
        m_wen = 1'b0;
      end
      if (keep) m_q.push_back({bus.ll_rd, bus.ll_data});
      if (nonempty && !popped) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else                     m_starve = 0;
    end
    @(posedge clk);
    #1;
    check("wr_en",   64'(bus.wr_en),   64'(m_wen));
    check("rd_addr", 64'(bus.rd_addr), 64'(m_rd));
    check("wr_data", 64'(bus.wr_data), 64'(m_data));
`ifdef WB_X0_FILTER_EN
    check("x0_write", 64'(bus.wr_en && bus.rd_addr == 5'd0), 64'(0));
`endif
  endtask

  initial begin
    bit          lpend;
    bit          pvr;
    logic [4:0]  lrd;
    logic [31:0] ldat;

    // Power-up reset
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    m_q.delete(); m_wen = 0; m_rd = 0; m_data = 0; m_starve = 0;
    check("rst_wr_en",    64'(bus.wr_en),      64'(0));
    check("rst_rd_addr",  64'(bus.rd_addr),    64'(0));
    check("rst_wr_data",  64'(bus.wr_data),    64'(0));
    check("rst_count",    64'(bus.fifo_count), 64'(0));
    check("rst_stall",    64'(bus.pipe_stall), 64'(0));
    check("rst_ll_ready", 64'(bus.ll_ready),   64'(0));
    rst = 1'b0;

    // Pipeline result, 1-cycle latency
    drive(1'b1, 5'd5, 32'h1111_1111, 1'b0, 5'd0, 32'd0);
    cyc();
    check("pipe_wr_en", 64'(bus.wr_en),   64'(1));
    check("pipe_rd",    64'(bus.rd_addr), 64'(5));
    check("pipe_data",  64'(bus.wr_data), 64'(32'h1111_1111));
    idle();
    cyc();
    check("pipe_wr_en_off", 64'(bus.wr_en), 64'(0));

    // Long-latency bypass with empty FIFO
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7777_7777);
    cyc();
    check("byp_fired", 64'(m_fired),         64'(1));
    check("byp_count", 64'(bus.fifo_count),  64'(0));
    check("byp_wr_en", 64'(bus.wr_en),       64'(1));
    check("byp_rd",    64'(bus.rd_addr),     64'(7));
    check("byp_data",  64'(bus.wr_data),     64'(32'h7777_7777));

    // Pipeline owns port for 3 cycles while ll pushes x8 then x9
    drive(1'b1, 5'd20, 32'h2020_2020, 1'b1, 5'd8, 32'h8888_8888);
    cyc();
    drive(1'b1, 5'd21, 32'h2121_2121, 1'b1, 5'd9, 32'h9999_9999);
    cyc();
    drive(1'b1, 5'd22, 32'h2222_2222, 1'b0, 5'd0, 32'd0);
    cyc();
    check("full_count", 64'(bus.fifo_count), 64'(2));
    check("full_ready", 64'(bus.ll_ready),   64'(0));
    idle();
    cyc();
    check("drain0_rd",   64'(bus.rd_addr), 64'(8));
    check("drain0_data", 64'(bus.wr_data), 64'(32'h8888_8888));
    cyc();
    check("drain1_rd",   64'(bus.rd_addr), 64'(9));
    check("drain1_wr",   64'(bus.wr_en),   64'(1));
    cyc();
    check("drain_done", 64'(bus.wr_en), 64'(0));

    // Starvation: one buffered entry, pipeline holds the port
    drive(1'b1, 5'd10, 32'h1010_1010, 1'b1, 5'd12, 32'h1212_1212);
    cyc();
    drive(1'b1, 5'd11, 32'h1111_0000, 1'b0, 5'd0, 32'd0);
    repeat (3) cyc();
    check("starve_3", 64'(bus.pipe_stall), 64'(0));
    cyc();
    check("starve_4", 64'(bus.pipe_stall), 64'(1));
    idle();
    cyc();
    check("starve_pop_rd", 64'(bus.rd_addr),    64'(12));
    check("starve_clear",  64'(bus.pipe_stall), 64'(0));

    // Reset mid-operation with a full FIFO and an active write
    drive(1'b1, 5'd15, 32'h1515_1515, 1'b1, 5'd13, 32'h1313_1313);
    cyc();
    drive(1'b1, 5'd16, 32'h1616_1616, 1'b1, 5'd14, 32'h1414_1414);
    cyc();
    check("pre_rst_count", 64'(bus.fifo_count), 64'(2));
    check("pre_rst_wr_en", 64'(bus.wr_en),      64'(1));
    rst = 1'b1;
    idle();
    cyc();
    rst = 1'b0;
    check("mid_rst_wr_en", 64'(bus.wr_en),      64'(0));
    check("mid_rst_rd",    64'(bus.rd_addr),    64'(0));
    check("mid_rst_data",  64'(bus.wr_data),    64'(0));
    check("mid_rst_count", 64'(bus.fifo_count), 64'(0));
    check("mid_rst_stall", 64'(bus.pipe_stall), 64'(0));
    repeat (3) begin
      cyc();
      check("flushed_no_write", 64'(bus.wr_en), 64'(0));
    end

    // x0 handling
    drive(1'b1, 5'd1, 32'h0101_0101, 1'b1, 5'd3, 32'h0303_0303);
    cyc();
    drive(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    cyc();
`ifdef WB_X0_FILTER_EN
    check("x0_pop_wr", 64'(bus.wr_en),   64'(1));
    check("x0_pop_rd", 64'(bus.rd_addr), 64'(3));
    idle();
    cyc();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hCAFE_F00D);
    cyc();
    check("x0_ll_fired", 64'(m_fired),        64'(1));
    check("x0_ll_no_wr", 64'(bus.wr_en),      64'(0));
    check("x0_ll_count", 64'(bus.fifo_count), 64'(0));
`else
    check("x0_wr",   64'(bus.wr_en),   64'(1));
    check("x0_rd",   64'(bus.rd_addr), 64'(0));
    check("x0_data", 64'(bus.wr_data), 64'(32'hDEAD_BEEF));
    idle();
    cyc();
    check("x0_then_pop", 64'(bus.rd_addr), 64'(3));
`endif
    idle();
    cyc();

    // Randomized traffic against the model
    lpend = 1'b0;
    lrd   = '0;
    ldat  = '0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!lpend && $urandom_range(0, 2) != 0) begin
        lpend = 1'b1;
        lrd   = 5'($urandom_range(0, 31));
        ldat  = $urandom;
      end
      pvr = ($urandom_range(0, 1) == 1) && (m_starve < LIMIT || $urandom_range(0, 3) == 0);
      drive(pvr, 5'($urandom_range(0, 31)), $urandom, lpend, lrd, ldat);
      cyc();
      if (m_fired) lpend = 1'b0;
    end
    rst = 1'b0;
    idle();
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_arbiter

`default_nettype wire
